vx_perf_pipeline_ctrl: RTL

Performance-counter controller for the core pipeline. It accumulates per-cycle event pulses from decode (loads, stores, branches) and issue (per-unit stall sources) into `PERF_CTR_BITS`-wide counters. It also serves 32-bit CSR reads through a valid/ready request/response port, and guarantees a tear-free low/high read pair by using a snapshot shadow register. It sits between the decode/issue stages and the CSR unit, and replaces direct wiring of raw counter buses.

---
 rtl/vx_perf_pipeline_ctrl_pkg.sv | 28 ++
 rtl/vx_perf_pipeline_ctrl_if.sv | 23 ++
 rtl/vx_perf_pipeline_ctrl_counter.sv | 27 ++
 rtl/vx_perf_pipeline_ctrl.sv | 84 ++++++++
 4 files changed

// File: rtl/vx_perf_pipeline_ctrl_pkg.sv
// Event index map and FSM state encoding shared by the performance-counter
// controller and its clients.
package vx_perf_pkg;

  localparam bit EXT_F_ENABLE = 1'b1;

  localparam int PERF_EVT_LOADS    = 0;
  localparam int PERF_EVT_STORES   = 1;
  localparam int PERF_EVT_BRANCHES = 2;
  localparam int PERF_EVT_IBF_ST   = 3;
  localparam int PERF_EVT_SCB_ST   = 4;
  localparam int PERF_EVT_LSU_ST   = 5;
  localparam int PERF_EVT_CSR_ST   = 6;
  localparam int PERF_EVT_ALU_ST   = 7;
  localparam int PERF_EVT_GPU_ST   = 8;
  localparam int PERF_EVT_FPU_ST   = 9;

  localparam int PERF_NUM_EVENTS = EXT_F_ENABLE ? 10 : 9;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    RESP = ST_RESP
  } perf_state_e;

endpackage

// File: rtl/vx_perf_pipeline_ctrl_if.sv
// CSR read request/response channel of the performance-counter controller.
interface vx_perf_pipeline_ctrl_if #(
  parameter int IDX_BITS = 4
);
  logic                req_valid;
  logic                req_ready;
  logic [IDX_BITS-1:0] req_idx;
  logic                req_hi;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic                rsp_err;

  modport master (
    output req_valid, req_idx, req_hi, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_idx, req_hi, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/vx_perf_pipeline_ctrl_counter.sv
// One event counter with synchronous clear and a sticky wrap flag.
module vx_perf_counter #(
  parameter int CTR_BITS = 44
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                evt,
  output logic [CTR_BITS-1:0] count,
  output logic                ovf
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (enable && evt) begin
      count <= count + CTR_BITS'(1);
      if (&count) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/vx_perf_pipeline_ctrl.sv
// Pipeline performance counters with a tear-free 32-bit CSR read port.
//
//   state   | meaning
//   IDLE    | req_ready=1, waiting for a read request
//   RESP    | rsp_valid=1, holding captured data until rsp_ready
module vx_perf_pipeline_ctrl
  import vx_perf_pkg::*;
#(
  parameter int CTR_BITS   = 44,
  parameter int NUM_EVENTS = PERF_NUM_EVENTS,
  parameter int IDX_BITS   = $clog2(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [NUM_EVENTS-1:0] events,
  output logic [NUM_EVENTS-1:0] ovf,
  vx_perf_pipeline_ctrl_if.slave csr
);

  logic [CTR_BITS-1:0] ctr_val [NUM_EVENTS];
  logic [IDX_BITS-1:0] idx;
  logic                idx_ok;
  logic [63:0]         sel_val;
  logic [31:0]         shadow;
  logic [0:0]          state;
  logic [31:0]         rsp_data_q;
  logic                rsp_err_q;

  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_ctr
    vx_perf_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (clear),
      .evt    (events[i]),
      .count  (ctr_val[i]),
      .ovf    (ovf[i])
    );
  end

  assign idx = csr.req_idx;

  // Out-of-range indices leave sel_val at zero, which is the required data.
  always_comb begin
    idx_ok  = 32'(idx) < 32'(NUM_EVENTS);
    sel_val = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (idx == IDX_BITS'(i)) sel_val = 64'(ctr_val[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      shadow     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (csr.req_valid) begin
            state      <= ST_RESP;
            rsp_err_q  <= !idx_ok;
            rsp_data_q <= csr.req_hi ? shadow : sel_val[31:0];
            if (!csr.req_hi && idx_ok) shadow <= sel_val[63:32];
          end
        end
        ST_RESP: begin
          if (csr.rsp_ready) state <= ST_IDLE;
        end
      endcase
      // Clear zeroes the shadow but leaves an already captured response alone.
      if (clear) shadow <= '0;
    end
  end

  assign csr.req_ready = (state == ST_IDLE);
  assign csr.rsp_valid = (state == ST_RESP);
  assign csr.rsp_data  = rsp_data_q;
  assign csr.rsp_err   = rsp_err_q;

endmodule
